// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 serial-SRAM (READ/WRITE) target bridged to Wishbone.
// Define SPI_SRAM_TARGET_DUMMY_EN to insert an 8-clock dummy byte before read data.
module spi_sram_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sck,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [23:0] adr_o,
  output logic [7:0]  dat_o,
  input  logic [7:0]  dat_i,
  input  logic        ack_i,
  output logic        err_o
);
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RDATA, DUMMY, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q;
  logic sck_d, cs_d;
  logic sck_s, mosi_s, cs_s;
  logic rise, fall, cs_fall;

  assign sck_s   = sck_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign cs_s    = cs_q[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_d;
  assign fall    = ~sck_s & sck_d;
  assign cs_fall = cs_d & ~cs_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_q  <= '0;
      mosi_q <= '0;
      cs_q   <= '1;
      sck_d  <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sck_d  <= sck_s;
      cs_d   <= cs_s;
    end
  end

  state_t      state;
  logic [4:0]  bitcnt;
  logic [6:0]  sr;
  logic [6:0]  tx;
  logic [23:0] addr;
  logic [7:0]  hold;
  logic        hold_vld;
  logic        rd_op;
  logic        rd_pend;
  logic        rd_drop;
  logic [7:0]  rx_byte;
  logic        ack_rd;
  logic        avail;
  logic [7:0]  next_tx;

  assign rx_byte = {sr, mosi_s};
  // read data acked this very clock is used directly at a byte start
  assign ack_rd  = cyc_o & ack_i & ~we_o & ~rd_drop;
  assign avail   = hold_vld | ack_rd;
  assign next_tx = hold_vld ? hold : (ack_rd ? dat_i : 8'h00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      bitcnt   <= '0;
      sr       <= '0;
      tx       <= '0;
      addr     <= '0;
      hold     <= '0;
      hold_vld <= 1'b0;
      rd_op    <= 1'b0;
      rd_pend  <= 1'b0;
      rd_drop  <= 1'b0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
      adr_o    <= '0;
      dat_o    <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o   <= 1'b0;
      miso_oe <= ~cs_s & ((state == RDATA) | (state == DUMMY));
      if (cyc_o && ack_i) begin
        cyc_o   <= 1'b0;
        stb_o   <= 1'b0;
        rd_drop <= 1'b0;
        if (!we_o && !rd_drop &&
            (state == RDATA || state == DUMMY)) begin
          hold     <= dat_i;
          hold_vld <= 1'b1;
        end
      end
      if (rd_pend && !cyc_o && !cs_s && state == RDATA) begin
        cyc_o   <= 1'b1;
        stb_o   <= 1'b1;
        we_o    <= 1'b0;
        adr_o   <= addr;
        rd_pend <= 1'b0;
      end
      if (cs_s) begin
        state    <= IDLE;
        bitcnt   <= '0;
        miso     <= 1'b0;
        hold_vld <= 1'b0;
        rd_pend  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (cs_fall && !cyc_o) begin
            state  <= CMD;
            bitcnt <= '0;
          end
          CMD: if (rise) begin
            sr     <= rx_byte[6:0];
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd7) begin
              bitcnt <= '0;
              rd_op  <= (rx_byte == 8'h03);
              if (rx_byte == 8'h02 || rx_byte == 8'h03)
                state <= ADDR;
              else
                state <= IGNORE;
            end
          end
          ADDR: if (rise) begin
            addr   <= {addr[22:0], mosi_s};
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd23) begin
              bitcnt <= '0;
              if (!rd_op) begin
                state <= WDATA;
              end else begin
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                we_o  <= 1'b0;
                adr_o <= {addr[22:0], mosi_s};
`ifdef SPI_SRAM_TARGET_DUMMY_EN
                state <= DUMMY;
`else
                state <= RDATA;
`endif
              end
            end
          end
          WDATA: if (rise) begin
            sr     <= rx_byte[6:0];
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd7) begin
              bitcnt <= '0;
              addr   <= addr + 24'd1;
              if (cyc_o) begin
                err_o <= 1'b1;
              end else begin
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                we_o  <= 1'b1;
                adr_o <= addr;
                dat_o <= rx_byte;
              end
            end
          end
          RDATA: if (fall) begin
            bitcnt <= (bitcnt == 5'd7) ? 5'd0 : bitcnt + 5'd1;
            if (bitcnt == 5'd0) begin
              tx       <= next_tx[6:0];
              miso     <= next_tx[7];
              err_o    <= ~avail;
              hold_vld <= 1'b0;
              addr     <= addr + 24'd1;
              if (cyc_o) begin
                rd_pend <= 1'b1;
                // a late read must not land in the following byte
                if (!ack_i) rd_drop <= 1'b1;
              end else begin
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                we_o  <= 1'b0;
                adr_o <= addr + 24'd1;
              end
            end else begin
              tx   <= {tx[5:0], 1'b0};
              miso <= tx[6];
            end
          end
`ifdef SPI_SRAM_TARGET_DUMMY_EN
          DUMMY: if (rise) begin
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd7) begin
              bitcnt <= '0;
              state  <= RDATA;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_sram_target.sv
// Directed bench for spi_sram_target: SPI initiator tasks plus a Wishbone memory model.
// Honors SPI_SRAM_TARGET_DUMMY_EN to exercise the dummy-byte read path.
module tb_spi_sram_target;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        miso, miso_oe, cyc_o, stb_o, we_o, err_o;
  logic [23:0] adr_o;
  logic [7:0]  dat_o, dat_i;
  logic        ack_i;

  spi_sram_target #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sck(sck), .mosi(mosi),
    .cs_n(cs_n), .miso(miso), .miso_oe(miso_oe), .cyc_o(cyc_o),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int half = 4;
  int ack_dly = 0;
  int wcnt;
  int err_cnt = 0;
  int mon_bad = 0;
  int stb_bad = 0;
  bit mon = 1'b0;
  logic [23:0] wr_adr[$];
  logic [7:0]  wr_dat[$];
  logic [23:0] rd_adr[$];
  logic [7:0]  rxb[8];

  assign dat_i = adr_o[7:0] ^ 8'h5A;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_i <= 1'b0;
      wcnt  <= 0;
    end else begin
      ack_i <= 1'b0;
      if (cyc_o && !ack_i) begin
        if (wcnt >= ack_dly) begin
          ack_i <= 1'b1;
          wcnt  <= 0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
      if (cyc_o && ack_i) begin
        if (we_o) begin
          wr_adr.push_back(adr_o);
          wr_dat.push_back(dat_o);
        end else begin
          rd_adr.push_back(adr_o);
        end
      end
      if (err_o) err_cnt <= err_cnt + 1;
      if (mon && (miso || miso_oe)) mon_bad <= mon_bad + 1;
      if (cyc_o !== stb_o) stb_bad <= stb_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic xfer_n(input logic [7:0] t, input int n,
                        output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = t[i];
      tick(half);
      sck = 1'b1;
      tick(half);
      r[i] = miso;
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] t, output logic [7:0] r);
    xfer_n(t, 8, r);
  endtask

  task automatic sel();
    cs_n = 1'b0;
    tick(2 * half);
  endtask

  task automatic desel();
    tick(half);
    cs_n = 1'b1;
    tick(40);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] r;
    xfer(op, r);
    xfer(a[23:16], r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
  endtask

  task automatic spi_read(input logic [23:0] a, input int n);
    logic [7:0] r;
    sel();
    hdr(8'h03, a);
`ifdef SPI_SRAM_TARGET_DUMMY_EN
    xfer(8'h00, r);
`endif
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, r);
      rxb[i] = r;
    end
    desel();
  endtask

  initial begin
    int wb, rb, eb, mb;
    logic [7:0] r;
    tick(3);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_adr", adr_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1'b1;
    tick(5);

    wb = wr_adr.size(); eb = err_cnt;
    sel();
    hdr(8'h02, 24'h000010);
    xfer(8'hA5, r);
    desel();
    chk("w1_count", wr_adr.size() - wb, 1);
    chk("w1_adr", wr_adr[wb], 24'h000010);
    chk("w1_dat", wr_dat[wb], 8'hA5);
    chk("w1_err", err_cnt - eb, 0);

    rb = rd_adr.size(); eb = err_cnt;
    spi_read(24'h000100, 4);
    chk("r4_b0", rxb[0], 8'h5A);
    chk("r4_b1", rxb[1], 8'h5B);
    chk("r4_b2", rxb[2], 8'h58);
    chk("r4_b3", rxb[3], 8'h59);
    chk("r4_count_ge4", 32'(rd_adr.size() - rb >= 4), 1);
    if (rd_adr.size() - rb >= 4) begin
      chk("r4_a0", rd_adr[rb], 24'h000100);
      chk("r4_a1", rd_adr[rb+1], 24'h000101);
      chk("r4_a2", rd_adr[rb+2], 24'h000102);
      chk("r4_a3", rd_adr[rb+3], 24'h000103);
    end
    chk("r4_err", err_cnt - eb, 0);

    wb = wr_adr.size(); eb = err_cnt;
    sel();
    hdr(8'h02, 24'hFFFFFF);
    xfer(8'h11, r);
    xfer(8'h22, r);
    desel();
    chk("wrap_count", wr_adr.size() - wb, 2);
    if (wr_adr.size() - wb == 2) begin
      chk("wrap_a0", wr_adr[wb], 24'hFFFFFF);
      chk("wrap_d0", wr_dat[wb], 8'h11);
      chk("wrap_a1", wr_adr[wb+1], 24'h000000);
      chk("wrap_d1", wr_dat[wb+1], 8'h22);
    end
    chk("wrap_err", err_cnt - eb, 0);

    wb = wr_adr.size(); rb = rd_adr.size(); mb = mon_bad;
    mon = 1'b1;
    sel();
    xfer(8'h9F, r);
    for (int i = 0; i < 4; i++) xfer(8'hFF, r);
    desel();
    mon = 1'b0;
    chk("ign_wr", wr_adr.size() - wb, 0);
    chk("ign_rd", rd_adr.size() - rb, 0);
    chk("ign_pins", mon_bad - mb, 0);

    wb = wr_adr.size(); eb = err_cnt;
    sel();
    hdr(8'h02, 24'h000020);
    xfer_n(8'hC3, 4, r);
    desel();
    chk("abort_wr", wr_adr.size() - wb, 0);
    chk("abort_err", err_cnt - eb, 0);
    spi_read(24'h000030, 1);
    chk("abort_rd", rxb[0], 8'h6A);

    eb = err_cnt;
`ifdef SPI_SRAM_TARGET_DUMMY_EN
    half = 2;
    ack_dly = 6;
    spi_read(24'h000200, 2);
    chk("dly_b0", rxb[0], 8'h5A);
    chk("dly_b1", rxb[1], 8'h5B);
    chk("dly_err", err_cnt - eb, 0);
`else
    ack_dly = 20;
    spi_read(24'h000200, 2);
    chk("udr_b0", rxb[0], 8'h00);
    chk("udr_b1", rxb[1], 8'h5B);
    chk("udr_err", err_cnt - eb, 1);
`endif
    ack_dly = 0;
    half = 4;
    tick(20);
    chk("stb_eq_cyc", stb_bad, 0);
    chk("idle_cyc", cyc_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
